// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Byte-addressable data memory for the memory stage of the single-cycle CPU.
// Holds DEPTH bytes and performs 1, 2, 4 or 8-byte big-endian transfers.
// Load and store data are right-justified on the 64-bit data buses.
// Reads are combinational. Writes commit on the rising edge of clk.
// An active-low reset clears every byte immediately and blocks writes.
//
// Parameters:
//   DEPTH        memory size in bytes (power of two, >= 8)
//   DATA_WIDTH   data bus width in bits (fixed at 64)
//
// Ports:
//   clk           in   clock; writes occur on its rising edge
//   rst_n         in   asynchronous active-low reset; clears the whole memory
//   address       in   byte address of the first (most-significant) byte
//   write_enable  in   commit write_data at the next rising edge
//   read_enable   in   drive read_data from memory
//   write_data    in   store data, right-justified (low N bytes used)
//   xfer_size     in   one-hot transfer size: 0001=1, 0010=2, 0100=4, 1000=8
//   read_data     out  load data, right-justified and zero-extended
//
// Configuration macro:
//   DATAMEM_ALIGN_CHECK_EN  when defined, compiles simulation-only $error
//                           checks for illegal size, misalignment and
//                           out-of-range addresses. Function is unchanged.
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [63:0]           address,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [3:0]            xfer_size,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int AW = $clog2(DEPTH);

    // Elaboration-time parameter sanity checks.
    if (DATA_WIDTH != 64) begin : g_bad_width
        $error("data_memory: DATA_WIDTH must be 64");
    end
    if (DEPTH < 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("data_memory: DEPTH must be a power of two and >= 8");
    end

    logic [7:0]    r_mem [DEPTH];

    logic          w_size_ok;
    logic [3:0]    w_nbytes;
    logic [5:0]    w_lshift;
    logic [AW-1:0] w_idx [8];
    logic [63:0]   w_wr_aligned;
    logic [63:0]   w_rd_acc;

    // Size decode. The left shift moves the N right-justified store bytes
    // to the top of the word, so transfer byte k always sits at bits
    // [63-8k -: 8] regardless of N.
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        w_size_ok = 1'b1;
        w_nbytes  = 4'd0;
        w_lshift  = 6'd0;
        unique case (xfer_size)
            4'b0001: begin w_nbytes = 4'd1; w_lshift = 6'd56; end
            4'b0010: begin w_nbytes = 4'd2; w_lshift = 6'd48; end
            4'b0100: begin w_nbytes = 4'd4; w_lshift = 6'd32; end
            4'b1000: begin w_nbytes = 4'd8; w_lshift = 6'd0;  end
            default: w_size_ok = 1'b0;
        endcase
    end

    // Byte indices of the transfer; AW-bit arithmetic gives the modulo-DEPTH
    // wrap for free, both for upper address bits and for end-wrapping bursts.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_idx[k] = address[AW-1:0] + AW'(k);
        end
    end

    assign w_wr_aligned = write_data << w_lshift;

    // Read assembly: shifting each new byte in from the right yields a
    // big-endian, right-justified, zero-extended result.
    always_comb begin
        w_rd_acc = '0;
        if (read_enable && w_size_ok) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < w_nbytes) begin
                    w_rd_acc = {w_rd_acc[55:0], r_mem[w_idx[k]]};
                end
            end
        end
    end

    assign read_data = w_rd_acc;

    // NOTE: the storage array is reset on purpose -- assertion of rst_n must
    // clear every byte at once, so the memory cannot map onto a plain RAM
    // macro without reset support.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (write_enable && w_size_ok) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < w_nbytes) begin
                    r_mem[w_idx[k]] <= w_wr_aligned[63-8*k -: 8];
                end
            end
        end
    end

`ifdef DATAMEM_ALIGN_CHECK_EN
    // Simulation-only access checks, sampled at each rising edge.
    always @(posedge clk) begin
        if (rst_n && (read_enable || write_enable)) begin
            if (!w_size_ok) begin
                $error("data_memory: illegal xfer_size %b", xfer_size);
            end else if ((address & (64'(w_nbytes) - 64'd1)) != 64'd0) begin
                $error("data_memory: address %h not aligned to %0d bytes",
                       address, w_nbytes);
            end
            if (address >= 64'(DEPTH)) begin
                $error("data_memory: address %h beyond DEPTH %0d",
                       address, DEPTH);
            end
        end
    end
`else
    // Upper address bits only matter to the checks; without them they are
    // intentionally dropped by the modulo-DEPTH indexing.
    logic w_unused_addr;
    assign w_unused_addr = ^address[63:AW];
`endif

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory
//
// Directed self-checking bench for data_memory (DEPTH = 1024). Expected
// values are hand-computed constants. Inputs change one time unit after a
// rising edge; combinational reads are sampled one further time unit later.
// -----------------------------------------------------------------------------
module tb_data_memory;

    logic        clk;
    logic        rst_n;
    logic [63:0] address;
    logic        write_enable;
    logic        read_enable;
    logic [63:0] write_data;
    logic [3:0]  xfer_size;
    logic [63:0] read_data;

    int n_checks;
    int n_fails;

    data_memory #(.DEPTH(1024), .DATA_WIDTH(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .address      (address),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .write_data   (write_data),
        .xfer_size    (xfer_size),
        .read_data    (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the run is short; anything beyond this means a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Combinational read: set inputs, settle, compare.
    task automatic rd(input string tag, input logic [63:0] addr,
                      input logic [3:0] size, input logic [63:0] exp);
        address     = addr;
        xfer_size   = size;
        read_enable = 1'b1;
        #1;
        check(tag, read_data, exp);
        read_enable = 1'b0;
    endtask

    // Single write across one rising edge; returns 1 unit after the edge.
    task automatic wr(input logic [63:0] addr, input logic [63:0] data,
                      input logic [3:0] size);
        address      = addr;
        write_data   = data;
        xfer_size    = size;
        write_enable = 1'b1;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst_n        = 1'b0;
        address      = '0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        write_data   = '0;
        xfer_size    = 4'b1000;

        repeat (2) @(posedge clk);
        #1;
        rd("reset_state", 64'h10, 4'b1000, 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted mid-cycle clears memory without a clock edge.
        wr(64'h10, 64'hDEAD_BEEF, 4'b0100);
        rd("pre_reset_word", 64'h10, 4'b0100, 64'hDEAD_BEEF);
        #2;
        rst_n = 1'b0;
        rd("async_reset_clear", 64'h10, 4'b1000, 64'h0);

        // Write attempted while reset is held is blocked.
        wr(64'h10, 64'h1234_5678, 4'b0100);
        rd("write_in_reset", 64'h10, 4'b0100, 64'h0);
        rst_n = 1'b1;

        // First write after release commits at the next edge.
        wr(64'h20, 64'h5A, 4'b0001);
        rd("first_write_after_release", 64'h20, 4'b0001, 64'h5A);

        // Doubleword round trip and byte order.
        wr(64'h08, 64'h0123_4567_89AB_CDEF, 4'b1000);
        rd("dword_read", 64'h08, 4'b1000, 64'h0123_4567_89AB_CDEF);
        rd("byte_msb", 64'h08, 4'b0001, 64'h01);
        rd("byte_lsb", 64'h0F, 4'b0001, 64'hEF);

        // Partial write: only two bytes change, upper data bits ignored.
        wr(64'h0A, 64'hFFFF_FFFF_FFFF_AA55, 4'b0010);
        rd("partial_write", 64'h08, 4'b1000, 64'h0123_AA55_89AB_CDEF);

        // Sub-word read and disabled read.
        rd("word_read", 64'h0C, 4'b0100, 64'h0000_0000_89AB_CDEF);
        address     = 64'h0C;
        xfer_size   = 4'b0100;
        read_enable = 1'b0;
        #1;
        check("read_disabled", read_data, 64'h0);

        // Illegal sizes: no read data, no write.
        rd("illegal_read_size", 64'h08, 4'b0000, 64'h0);
        wr(64'h08, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0011);
        rd("illegal_write_size", 64'h08, 4'b1000, 64'h0123_AA55_89AB_CDEF);

        // Same-cycle read and write: old before the edge, new after it.
        address      = 64'h08;
        xfer_size    = 4'b1000;
        write_data   = 64'h1122_3344_5566_7788;
        write_enable = 1'b1;
        read_enable  = 1'b1;
        #1;
        check("rw_before_edge", read_data, 64'h0123_AA55_89AB_CDEF);
        @(posedge clk);
        #1;
        check("rw_after_edge", read_data, 64'h1122_3344_5566_7788);
        write_enable = 1'b0;
        read_enable  = 1'b0;

        // Misaligned doubleword read running past written bytes into zeros.
        rd("misaligned_read", 64'h0B, 4'b1000, 64'h4455_6677_8800_0000);

        // Address wrap: 0x400 aliases 0x000.
        wr(64'h400, 64'hBEEF, 4'b0010);
        rd("wrap_halfword", 64'h000, 4'b0010, 64'hBEEF);
        rd("wrap_byte0", 64'h000, 4'b0001, 64'hBE);
        rd("wrap_byte1", 64'h001, 4'b0001, 64'hEF);

        // End-wrapping word: bytes at 0x3FE, 0x3FF, 0x000, 0x001.
        wr(64'h3FE, 64'hA1B2_C3D4, 4'b0100);
        rd("end_wrap_word", 64'h3FE, 4'b0100, 64'hA1B2_C3D4);
        rd("end_wrap_low", 64'h000, 4'b0010, 64'hC3D4);
        rd("upper_addr_ignored", 64'hFFFF_0000_0000_03FE, 4'b0100,
           64'hA1B2_C3D4);

        // Reset during a pending write: write lost, memory stays zero.
        address      = 64'h30;
        write_data   = 64'h77;
        xfer_size    = 4'b0001;
        write_enable = 1'b1;
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        write_enable = 1'b0;
        rst_n        = 1'b1;
        rd("reset_pending_write", 64'h30, 4'b0001, 64'h0);
        rd("reset_clears_dword", 64'h08, 4'b1000, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/data_memory.md
# data_memory

Byte-addressable data memory for the single-cycle CPU, instantiated as `datamem` in the memory stage. It stores 64-bit doublewords as bytes and supports 1, 2, 4 and 8-byte transfers. Reads are combinational from the ALU-computed address. Writes commit on the rising clock edge. Load and store data are big-endian and right-justified in the 64-bit data bus.

## Interface
- `DEPTH`, default 1024: memory size in bytes; power of two, ≥ 8.
- `DATA_WIDTH`, default 64: data bus width in bits; fixed at 64.
- `clk` input, 1 bit: the block's single clock; writes occur on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `address` input, 64 bits: byte address of the first (most-significant) byte of the transfer.
- `write_enable` input, 1 bit: commit `write_data` at the next rising edge.
- `read_enable` input, 1 bit: drive `read_data` from memory.
- `write_data` input, 64 bits: store data, right-justified; the low `xfer_size` bytes are used.
- `xfer_size` input, 4 bits: transfer size in bytes, one-hot.
  - Legal values: 4'b0001 = 1 byte, 4'b0010 = 2 bytes, 4'b0100 = 4 bytes, 4'b1000 = 8 bytes.
- `read_data` output, 64 bits: load data, right-justified and zero-extended.

## Operation
- **Storage:** `DEPTH` bytes, `mem[0..DEPTH-1]`.
- **Byte index:** byte index = `address[log2(DEPTH)-1:0]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH`.
- **Transfer size:** let N = decoded `xfer_size`.
- **Byte order (big-endian):** byte k of the transfer (k = 0..N-1) is `mem[(address+k) mod DEPTH]`. Byte k maps to data bits [8*(N-1-k)+7 : 8*(N-1-k)].
- **Read:** when `read_enable`=1 and `xfer_size` is legal, `read_data` = the N bytes assembled as above. Bits [63:8N] are 0.
- **Read disabled or illegal size:** `read_data` = 0 when `read_enable`=0 or `xfer_size` is illegal (not one-hot).
- **Write:** when `write_enable`=1, `xfer_size` is legal and `rst_n`=1, the N bytes are written at the rising edge of `clk`.
  - Only those N bytes change; all other bytes are unchanged.
  - `write_data` bits [63:8N] are ignored.
- **Illegal size on write:** no write occurs.
- **Independent enables:** `read_enable` and `write_enable` are independent; both may be 1 in the same cycle.

## Timing
- **Read latency:** read is combinational, zero cycles. `read_data` follows `address`, `xfer_size`, `read_enable` and memory contents within the same cycle.
- **Write latency:** a write commits at the rising edge. In the same cycle, a read of the written location returns the old data before the edge and the new data after it.
- **Reset assertion:** when `rst_n` falls, every byte of `mem` is cleared to 0 immediately, without waiting for `clk`.
  - `read_data` therefore becomes 0.
  - Writes are blocked for as long as `rst_n`=0.
- **Reset release:** on `rst_n` rising, the first write can commit at the next rising edge of `clk`.
- **Reset during a write:** if reset is asserted in the cycle of a pending write, the write is lost and the memory stays zero.
- **Misaligned access:** misaligned and end-wrapping multi-byte accesses follow the modulo-`DEPTH` byte rule above (see Configuration).

## Configuration
- **Macro:** `DATAMEM_ALIGN_CHECK_EN`.
- **Defined:** simulation-only checks are compiled in. On every cycle where `read_enable` or `write_enable` is 1 and `rst_n`=1, the block reports an `$error` if any of these hold:
  - `xfer_size` is not one-hot;
  - `address` is not a multiple of N;
  - `address` ≥ `DEPTH`.

  Functional behaviour is identical to the undefined case.
- **Undefined:** no checks are compiled. Illegal accesses silently follow the rules in Operation.

## Test plan
- **Reset clears memory:** drive `rst_n`=0 mid-cycle with no clock edge. Then read `address`=0x10 with size 8 and `read_enable`=1 → `read_data`=0x0 immediately.
- **Doubleword round trip:** write 0x0123456789ABCDEF at `address`=0x08, size 8.
  - After the edge, an 8-byte read returns 0x0123456789ABCDEF.
  - A 1-byte read at 0x08 returns 0x01; a 1-byte read at 0x0F returns 0xEF.
- **Partial writes:** starting from the word above, write 0xFFFF_FFFF_FFFF_AA55 with size 2 at 0x0A. An 8-byte read at 0x08 → 0x0123AA5589ABCDEF; the upper write bits are ignored.
- **Sub-word reads:** a 4-byte read at 0x0C → 0x0000000089ABCDEF. With `read_enable`=0 → 0x0.
- **Write gating:**
  - `write_enable`=1 with `xfer_size`=4'b0011 → memory unchanged.
  - A write attempted while `rst_n`=0 → memory stays 0.
  - Read and write of the same address in the same cycle → old value before the edge, new value after.
- **Address wrap:** with `DEPTH`=1024, write 0xBEEF with size 2 at address 0x400 → a read at 0x000 returns 0xBEEF.
  - With `DATAMEM_ALIGN_CHECK_EN` defined, this access and a size-4 access at 0x02 each report an error.
